// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial sequence recognizer:
// FSM state encoding and default sizing.
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

endpackage

// File: rtl/seq_det_matcher.sv
// Combinational masked compare of the bit window {history,x} against the
// stored pattern; only the low len bits take part in the compare.
module seq_det_matcher
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] window,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign hit = (((window ^ pattern) & mask) == '0);

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable Mealy sequence recognizer with run-time pattern/length load.
// Define SEQ_PATTERN_DETECTOR_MATCH_CNT_EN to build the saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               overlap,
    input  logic               one_shot,
    input  logic               x_valid,
    input  logic               x,
    output logic               z,
    output logic               armed,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   match_cnt
);

    state_t               state_q, state_d;
    logic [MAX_LEN-2:0]   history_q;
    logic [LEN_W-1:0]     fill_q;
    logic [MAX_LEN-1:0]   pat_q;
    logic [LEN_W-1:0]     len_q;
    logic                 overlap_q;
    logic                 one_shot_q;
    logic                 err_q;

    logic                 load_legal;
    logic [MAX_LEN-1:0]   window;
    logic [LEN_W:0]       fill_inc;
    logic                 fill_ok;
    logic                 hit;
    logic                 match;

    assign load_legal = (len_in != '0) && (int'(len_in) <= MAX_LEN);
    assign window     = {history_q, x};
    assign fill_inc   = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    assign fill_ok    = (fill_inc >= {1'b0, len_q});

    seq_det_matcher #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .window  (window),
        .pattern (pat_q),
        .len     (len_q),
        .hit     (hit)
    );

    // A load cycle never matches, even with a valid bit present.
    assign match = (state_q == ST_RUN) & x_valid & ~load & fill_ok & hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_legal ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN:  if (match && one_shot_q) state_d = ST_LOCK;
                ST_LOCK: state_d = ST_LOCK;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        z     = match;
        armed = (state_q == ST_RUN);
        done  = (state_q == ST_LOCK);
        err   = err_q;
    end

    // Pattern configuration, bit history and fill level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            history_q  <= '0;
            fill_q     <= '0;
            pat_q      <= '0;
            len_q      <= '0;
            overlap_q  <= 1'b0;
            one_shot_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (load) begin
            if (load_legal) begin
                pat_q      <= pat_in;
                len_q      <= len_in;
                overlap_q  <= overlap;
                one_shot_q <= one_shot;
                err_q      <= 1'b0;
                history_q  <= '0;
                fill_q     <= '0;
            end else begin
                err_q <= 1'b1;
            end
        end else if ((state_q == ST_RUN) && x_valid) begin
            if (match && !overlap_q) begin
                history_q <= '0;
                fill_q    <= '0;
            end else begin
                history_q <= window[MAX_LEN-2:0];
                if (int'(fill_q) < MAX_LEN) begin
                    fill_q <= fill_q + LEN_W'(1);
                end
            end
        end
    end

`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            if (load_legal) cnt_q <= '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: scenario tasks with a z
// scoreboard queue and inline status comparisons.
module tb_seq_pattern_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = 2;
`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic               clock;
    logic               reset;
    logic               load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   len_in;
    logic               overlap;
    logic               one_shot;
    logic               x_valid;
    logic               x;
    logic               z;
    logic               armed;
    logic               done;
    logic               err;
    logic [CNT_W-1:0]   match_cnt;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    seq_pattern_detector #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .pat_in    (pat_in),
        .len_in    (len_in),
        .overlap   (overlap),
        .one_shot  (one_shot),
        .x_valid   (x_valid),
        .x         (x),
        .z         (z),
        .armed     (armed),
        .done      (done),
        .err       (err),
        .match_cnt (match_cnt)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
        int sat;
        sat = (1 << CNT_W) - 1;
        if (CNT_ON == 0) return '0;
        return CNT_W'((n > sat) ? sat : n);
    endfunction

    // driver: one bit per cycle, expected z pushed, then popped against the DUT
    task automatic drive_bit(input logic v, input logic b, input logic ez, input string name);
        logic e;
        @(negedge clock);
        x_valid = v;
        x       = b;
        exp_q.push_back(ez);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (z !== e) begin
            errors++;
            $display("FAIL %s: z=%b expected %b", name, z, e);
        end
    endtask

    task automatic settle();
        @(posedge clock);
        #1;
        x_valid = 1'b0;
        x       = 1'b0;
    endtask

    task automatic do_load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ov, input logic os);
        @(negedge clock);
        load     = 1'b1;
        pat_in   = pat;
        len_in   = len;
        overlap  = ov;
        one_shot = os;
        x_valid  = 1'($urandom_range(0, 1));
        x        = 1'($urandom_range(0, 1));
        #2;
        checks++;
        if (z !== 1'b0) begin
            errors++;
            $display("FAIL load_z: z=%b expected 0", z);
        end
        @(posedge clock);
        #1;
        load     = 1'b0;
        x_valid  = 1'b0;
        pat_in   = MAX_LEN'($urandom);
        len_in   = LEN_W'($urandom_range(0, 15));
        overlap  = 1'($urandom_range(0, 1));
        one_shot = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load = 0; pat_in = '0; len_in = '0; overlap = 0; one_shot = 0; x_valid = 0; x = 0;
        repeat (2) @(posedge clock);
        #1;
        checks += 5;
        if (z !== 1'b0)         begin errors++; $display("FAIL rst_z: z=%b expected 0", z); end
        if (armed !== 1'b0)     begin errors++; $display("FAIL rst_armed: armed=%b expected 0", armed); end
        if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: done=%b expected 0", done); end
        if (err !== 1'b0)       begin errors++; $display("FAIL rst_err: err=%b expected 0", err); end
        if (match_cnt !== '0)   begin errors++; $display("FAIL rst_cnt: cnt=%0d expected 0", match_cnt); end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0, "idle_z");
        settle();
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL idle_armed: armed=%b expected 0", armed); end
    endtask

    task automatic test_overlap();
        logic [6:0] bits, ez;
        bits = 7'b1011011;
        ez   = 7'b0001001;
        do_load(8'b1011, 4'd4, 1'b1, 1'b0);
        checks += 3;
        if (armed !== 1'b1)   begin errors++; $display("FAIL ov_armed: armed=%b expected 1", armed); end
        if (err !== 1'b0)     begin errors++; $display("FAIL ov_err: err=%b expected 0", err); end
        if (match_cnt !== '0) begin errors++; $display("FAIL ov_cnt0: cnt=%0d expected 0", match_cnt); end
        for (int i = 6; i >= 0; i--) drive_bit(1'b1, bits[i], ez[i], "overlap_z");
        settle();
        checks++;
        if (match_cnt !== exp_cnt(2)) begin
            errors++; $display("FAIL ov_cnt: cnt=%0d expected %0d", match_cnt, exp_cnt(2));
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] bits, ez;
        bits = 7'b1011011;
        ez   = 7'b0001000;
        do_load(8'b1011, 4'd4, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) drive_bit(1'b1, bits[i], ez[i], "nonov_z");
        settle();
        checks++;
        if (match_cnt !== exp_cnt(1)) begin
            errors++; $display("FAIL nonov_cnt: cnt=%0d expected %0d", match_cnt, exp_cnt(1));
        end
    endtask

    task automatic test_one_shot();
        do_load(8'b010, 4'd3, 1'b1, 1'b1);
        drive_bit(1'b1, 1'b0, 1'b0, "os_z");
        drive_bit(1'b1, 1'b1, 1'b0, "os_z");
        drive_bit(1'b1, 1'b0, 1'b1, "os_z");
        settle();
        checks += 3;
        if (done !== 1'b1)  begin errors++; $display("FAIL os_done: done=%b expected 1", done); end
        if (armed !== 1'b0) begin errors++; $display("FAIL os_armed: armed=%b expected 0", armed); end
        if (match_cnt !== exp_cnt(1)) begin
            errors++; $display("FAIL os_cnt: cnt=%0d expected %0d", match_cnt, exp_cnt(1));
        end
        drive_bit(1'b1, 1'b1, 1'b0, "lock_z");
        drive_bit(1'b1, 1'b0, 1'b0, "lock_z");
        settle();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL lock_done: done=%b expected 1", done); end
        do_load(8'b010, 4'd3, 1'b1, 1'b1);
        checks += 2;
        if (armed !== 1'b1) begin errors++; $display("FAIL reload_armed: armed=%b expected 1", armed); end
        if (done !== 1'b0)  begin errors++; $display("FAIL reload_done: done=%b expected 0", done); end
    endtask

    task automatic test_illegal_load();
        do_load(8'hff, 4'd0, 1'b1, 1'b0);
        checks += 3;
        if (err !== 1'b1)   begin errors++; $display("FAIL len0_err: err=%b expected 1", err); end
        if (armed !== 1'b0) begin errors++; $display("FAIL len0_armed: armed=%b expected 0", armed); end
        if (done !== 1'b0)  begin errors++; $display("FAIL len0_done: done=%b expected 0", done); end
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0, "len0_z");
        settle();
        do_load(8'h01, 4'(MAX_LEN + 1), 1'b1, 1'b0);
        checks += 2;
        if (err !== 1'b1)   begin errors++; $display("FAIL lenmax_err: err=%b expected 1", err); end
        if (armed !== 1'b0) begin errors++; $display("FAIL lenmax_armed: armed=%b expected 0", armed); end
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1, 1'b0, "lenmax_z");
        settle();
        do_load(8'b11, 4'd2, 1'b1, 1'b0);
        checks += 2;
        if (err !== 1'b0)   begin errors++; $display("FAIL legal_err: err=%b expected 0", err); end
        if (armed !== 1'b1) begin errors++; $display("FAIL legal_armed: armed=%b expected 1", armed); end
    endtask

    task automatic test_valid_gap();
        drive_bit(1'b1, 1'b1, 1'b0, "gap_z");
        drive_bit(1'b0, 1'b1, 1'b0, "gap_z");
        drive_bit(1'b1, 1'b1, 1'b1, "gap_z");
        drive_bit(1'b0, 1'b1, 1'b0, "gap_novalid_z");
        settle();
        checks++;
        if (match_cnt !== exp_cnt(1)) begin
            errors++; $display("FAIL gap_cnt: cnt=%0d expected %0d", match_cnt, exp_cnt(1));
        end
    endtask

    task automatic test_back_to_back();
        do_load(8'b11, 4'd2, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, "b2b_nonov_z");
        drive_bit(1'b1, 1'b1, 1'b1, "b2b_nonov_z");
        drive_bit(1'b1, 1'b1, 1'b0, "b2b_nonov_z");
        drive_bit(1'b1, 1'b1, 1'b1, "b2b_nonov_z");
        settle();
        do_load(8'b11, 4'd2, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, "b2b_ov_z");
        drive_bit(1'b1, 1'b1, 1'b1, "b2b_ov_z");
        drive_bit(1'b1, 1'b1, 1'b1, "b2b_ov_z");
        settle();
        checks++;
        if (match_cnt !== exp_cnt(2)) begin
            errors++; $display("FAIL b2b_cnt: cnt=%0d expected %0d", match_cnt, exp_cnt(2));
        end
    endtask

    task automatic test_reset_mid();
        do_load(8'b101, 4'd3, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, "rmid_z");
        drive_bit(1'b1, 1'b0, 1'b0, "rmid_z");
        @(negedge clock);
        x_valid = 1'b1;
        x       = 1'b1;
        reset   = 1'b0;
        #2;
        checks += 5;
        if (z !== 1'b0)       begin errors++; $display("FAIL rmid_z_low: z=%b expected 0", z); end
        if (armed !== 1'b0)   begin errors++; $display("FAIL rmid_armed: armed=%b expected 0", armed); end
        if (done !== 1'b0)    begin errors++; $display("FAIL rmid_done: done=%b expected 0", done); end
        if (err !== 1'b0)     begin errors++; $display("FAIL rmid_err: err=%b expected 0", err); end
        if (match_cnt !== '0) begin errors++; $display("FAIL rmid_cnt: cnt=%0d expected 0", match_cnt); end
        @(negedge clock);
        x_valid = 1'b0;
        reset   = 1'b1;
        drive_bit(1'b1, 1'b1, 1'b0, "post_rst_z");
        drive_bit(1'b1, 1'b0, 1'b0, "post_rst_z");
        drive_bit(1'b1, 1'b1, 1'b0, "post_rst_z");
        settle();
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL post_rst_armed: armed=%b expected 0", armed); end
    endtask

    task automatic test_saturation();
        do_load(8'b1, 4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_bit(1'b1, 1'b1, 1'b1, "sat_z");
            settle();
            checks++;
            if (match_cnt !== exp_cnt(i + 1)) begin
                errors++; $display("FAIL sat_cnt: cnt=%0d expected %0d", match_cnt, exp_cnt(i + 1));
            end
        end
        drive_bit(1'b1, 1'b0, 1'b0, "sat_zero_z");
        settle();
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_one_shot();
        test_illegal_load();
        test_valid_gap();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
